// File: rtl/moving_window_pkg.sv
// Shared types, constants and helpers for the moving-window average filter.
package moving_window_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic MODE_SLIDING = 1'b0;
  localparam logic MODE_BLOCK   = 1'b1;

  // Sum of 2^log_max samples of data_w bits needs log_max extra bits.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned log_max);
    return data_w + log_max;
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len_log,
                                            input int unsigned log_max);
    return (len_log > log_max) ? log_max : len_log;
  endfunction

endpackage

// File: rtl/sdp_ram_rf.sv
// Simple dual-port RAM, read-first on address collision, one-cycle read latency.
module sdp_ram_rf #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/moving_window_filter.sv
// Sliding boxcar or decimating block average over a runtime power-of-two window.
module moving_window_filter
  import moving_window_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LOG_MAX = 10,
  parameter int unsigned LEN_W   = $clog2(LOG_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic [LEN_W-1:0]  len_log,
  input  logic              block_mode,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              filled
);

  localparam int unsigned ACC_W = acc_width(DATA_W, LOG_MAX);
  localparam int unsigned CNT_W = LOG_MAX + 1;
  localparam int unsigned DEPTH = 1 << LOG_MAX;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        k_q, k_d;
  logic                    mode_q, mode_d;
  logic [LOG_MAX-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]       s1_din_q, s1_din_d;
  logic [DATA_W-1:0]       dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    filled_q, filled_d;

  logic [LEN_W-1:0]        k_in;
  logic                    cfg_change;
  logic                    accept;
  logic                    s2_go;
  logic [CNT_W-1:0]        win_len;
  logic [CNT_W-1:0]        cnt_next;
  logic                    last;
  logic [LOG_MAX-1:0]      rd_addr;
  logic [DATA_W-1:0]       rd_data;
  logic                    ram_we;
  logic signed [ACC_W-1:0] din_ext, old_ext, sum;

  assign k_in       = LEN_W'(clamp_len(32'(len_log), LOG_MAX));
  assign cfg_change = (k_in != k_q) || (block_mode != mode_q);
  assign accept     = din_valid && (state_q != ST_FLUSH) && !cfg_change;
  assign s2_go      = s1_valid_q && !cfg_change;
  assign win_len    = CNT_W'(1) << k_q;
  assign cnt_next   = cnt_q + CNT_W'(1);
  assign last       = (cnt_next == win_len);
  // A full-depth window wraps to the write address; read-first yields the oldest sample.
  assign rd_addr    = wr_ptr_q - LOG_MAX'(win_len);
  assign ram_we     = accept && (mode_q == MODE_SLIDING);

  sdp_ram_rf #(
    .WIDTH  (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (LOG_MAX)
  ) u_buf (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Stage-2 arithmetic; the evicted sample only counts once the window is full.
  always_comb begin
    din_ext = ACC_W'($signed(s1_din_q));
    old_ext = '0;
    if ((state_q == ST_RUN) && (mode_q == MODE_SLIDING)) begin
      old_ext = ACC_W'($signed(rd_data));
    end
    sum = acc_q + din_ext - old_ext;
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    mode_d       = mode_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    s1_valid_d   = accept;
    s1_din_d     = accept ? din : s1_din_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    filled_d     = filled_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + LOG_MAX'(1);
    end

    case (state_q)
      ST_FILL: begin
        if (s2_go) begin
          acc_d = sum;
          cnt_d = cnt_next;
          if (last) begin
            state_d      = ST_RUN;
            filled_d     = 1'b1;
            dout_valid_d = 1'b1;
            dout_d       = DATA_W'(sum >>> k_q);
            if (mode_q == MODE_BLOCK) begin
              acc_d = '0;
              cnt_d = '0;
            end
          end
        end
      end
      ST_RUN: begin
        if (s2_go) begin
          acc_d = sum;
          if (mode_q == MODE_SLIDING) begin
            dout_valid_d = 1'b1;
            dout_d       = DATA_W'(sum >>> k_q);
          end else begin
            cnt_d = cnt_next;
            if (last) begin
              dout_valid_d = 1'b1;
              dout_d       = DATA_W'(sum >>> k_q);
              acc_d        = '0;
              cnt_d        = '0;
            end
          end
        end
      end
      ST_FLUSH: begin
        state_d  = ST_FILL;
        acc_d    = '0;
        cnt_d    = '0;
        wr_ptr_d = '0;
        filled_d = 1'b0;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    // Config change cancels the in-flight sample and drops the current one.
    if (cfg_change) begin
      state_d      = ST_FLUSH;
      k_d          = k_in;
      mode_d       = block_mode;
      acc_d        = '0;
      cnt_d        = '0;
      wr_ptr_d     = '0;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      filled_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FILL;
      k_q          <= k_in;
      mode_q       <= block_mode;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_din_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      filled_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      mode_q       <= mode_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      s1_valid_q   <= s1_valid_d;
      s1_din_q     <= s1_din_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      filled_q     <= filled_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign filled     = filled_q;

endmodule
